// File: rtl/slow_split_pkg.sv
// Shared types and helpers for the slow_split lane fan-out.
// Default widths double as the parameter defaults of the top and bus.
package slow_split_pkg;

    typedef enum logic [2:0] {
        SM_INIT,
        SM_GET_INPUT,
        SM_MULT,
        SM_CLIP,
        SM_SEND_OUTPUT
    } state_t;

    localparam int C_DWIDTH     = 16;
    localparam int C_BUS_WIDTH  = 4;
    localparam int C_GAIN_WIDTH = 16;
    localparam int C_GAIN_FRAC  = 14;

    function automatic int prod_w(input int dw, input int gw);
        return dw + gw;
    endfunction

endpackage

// File: rtl/slow_split_if.sv
// Sample-in / lanes-out valid-ready bus of slow_split.
// The DUT takes the slave view, the source/sink side the master view.
interface slow_split_if
    import slow_split_pkg::*;
#(
    parameter int G_DWIDTH     = C_DWIDTH,
    parameter int G_BUS_WIDTH  = C_BUS_WIDTH,
    parameter int G_GAIN_WIDTH = C_GAIN_WIDTH
);

    logic signed [G_DWIDTH-1:0]     din;
    logic signed [G_GAIN_WIDTH-1:0] gain [0:G_BUS_WIDTH-1];
    logic                           din_valid;
    logic                           din_ready;
    logic signed [G_DWIDTH-1:0]     dout [0:G_BUS_WIDTH-1];
    logic                           dout_valid;
    logic                           dout_ready;

    modport master (
        output din, gain, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, gain, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );

endinterface

// File: rtl/slow_split_round_clip.sv
// Round-half-up right shift by G_FRAC followed by saturation to G_OUT_W.
// One guard bit on the sum keeps the rounding offset from overflowing.
module slow_split_round_clip #(
    parameter int G_IN_W  = 32,
    parameter int G_FRAC  = 14,
    parameter int G_OUT_W = 16
) (
    input  logic signed [G_IN_W-1:0]  x_i,
    output logic signed [G_OUT_W-1:0] y_o
);

    localparam int W = G_IN_W + 1;

    localparam logic signed [W-1:0] HALF = W'(1) << (G_FRAC - 1);
    localparam logic signed [W-1:0] HI   = W'({1'b0, {(G_OUT_W-1){1'b1}}});
    localparam logic signed [W-1:0] LO   = ~HI;

    logic signed [W-1:0] sum;
    logic signed [W-1:0] shr;

    always_comb begin
        sum = W'(x_i) + HALF;
        shr = sum >>> G_FRAC;
        if (shr > HI) begin
            y_o = HI[G_OUT_W-1:0];
        end else if (shr < LO) begin
            y_o = LO[G_OUT_W-1:0];
        end else begin
            y_o = shr[G_OUT_W-1:0];
        end
    end

endmodule

// File: rtl/slow_split.sv
// Single sample to G_BUS_WIDTH lanes with per-lane gain, computed serially
// through one shared multiplier and presented as one output beat.
module slow_split
    import slow_split_pkg::*;
#(
    parameter int G_DWIDTH     = C_DWIDTH,
    parameter int G_BUS_WIDTH  = C_BUS_WIDTH,
    parameter int G_GAIN_WIDTH = C_GAIN_WIDTH,
    parameter int G_GAIN_FRAC  = C_GAIN_FRAC
) (
    input logic        clk,
    input logic        reset,
    input logic        enable,
    slow_split_if.slave bus
);

    localparam int PW = prod_w(G_DWIDTH, G_GAIN_WIDTH);
    localparam int LW = $clog2(G_BUS_WIDTH);
    localparam logic [LW-1:0] LAST = LW'(G_BUS_WIDTH - 1);

    typedef logic signed [G_DWIDTH-1:0]     samp_t;
    typedef logic signed [G_GAIN_WIDTH-1:0] gain_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic              prime_q, prime_d;
    samp_t             din_store_q, din_store_d;
    gain_t             gain_store_q [0:G_BUS_WIDTH-1];
    gain_t             gain_store_d [0:G_BUS_WIDTH-1];
    logic signed [PW-1:0] prod_q, prod_d;
    samp_t             out_store_q [0:G_BUS_WIDTH-1];
    samp_t             out_store_d [0:G_BUS_WIDTH-1];
    samp_t             dout_q [0:G_BUS_WIDTH-1];
    samp_t             dout_d [0:G_BUS_WIDTH-1];
    logic              dout_valid_q, dout_valid_d;
    logic              din_ready_q, din_ready_d;
    samp_t             clip_y;

    slow_split_round_clip #(
        .G_IN_W  (PW),
        .G_FRAC  (G_GAIN_FRAC),
        .G_OUT_W (G_DWIDTH)
    ) u_round_clip (
        .x_i (prod_q),
        .y_o (clip_y)
    );

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        prime_d      = prime_q;
        din_store_d  = din_store_q;
        gain_store_d = gain_store_q;
        prod_d       = prod_q;
        out_store_d  = out_store_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        din_ready_d  = din_ready_q;

        unique case (state_q)
            SM_INIT: begin
                din_ready_d = 1'b1;
                state_d     = SM_GET_INPUT;
            end
            SM_GET_INPUT: begin
                if (bus.din_valid && din_ready_q) begin
                    din_store_d  = bus.din;
                    gain_store_d = bus.gain;
                    din_ready_d  = 1'b0;
                    lane_d       = '0;
                    prime_d      = 1'b1;
                    state_d      = SM_MULT;
                end
            end
            SM_MULT: begin
                // First visit after capture is an idle slot: keeps
                // accept-to-valid at 2*lanes+1 cycles.
                if (prime_q) begin
                    prime_d = 1'b0;
                end else begin
                    prod_d  = din_store_q * gain_store_q[lane_q];
                    state_d = SM_CLIP;
                end
            end
            SM_CLIP: begin
                out_store_d[lane_q] = clip_y;
                if (lane_q == LAST) begin
                    dout_d       = out_store_d;
                    dout_valid_d = 1'b1;
                    state_d      = SM_SEND_OUTPUT;
                end else begin
                    lane_d  = lane_q + 1'b1;
                    state_d = SM_MULT;
                end
            end
            SM_SEND_OUTPUT: begin
                if (dout_valid_q && bus.dout_ready) begin
                    dout_valid_d = 1'b0;
                    din_ready_d  = 1'b1;
                    state_d      = SM_GET_INPUT;
                end
            end
            default: begin
                state_d = SM_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SM_INIT;
            lane_q       <= '0;
            prime_q      <= 1'b0;
            din_store_q  <= '0;
            gain_store_q <= '{default: '0};
            prod_q       <= '0;
            out_store_q  <= '{default: '0};
            dout_q       <= '{default: '0};
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b0;
        end else if (!enable) begin
            state_q      <= SM_INIT;
            lane_q       <= '0;
            prime_q      <= 1'b0;
            din_store_q  <= '0;
            gain_store_q <= '{default: '0};
            prod_q       <= '0;
            out_store_q  <= '{default: '0};
            dout_q       <= '{default: '0};
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            prime_q      <= prime_d;
            din_store_q  <= din_store_d;
            gain_store_q <= gain_store_d;
            prod_q       <= prod_d;
            out_store_q  <= out_store_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            din_ready_q  <= din_ready_d;
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;

endmodule

// File: tb/tb_slow_split.sv
// Scoreboard bench for slow_split: driver pushes expected lane vectors,
// a negedge monitor pops and compares on every output handshake.
module tb_slow_split;

    typedef logic [3:0][15:0] vec_t;

    logic clk;
    logic reset;
    logic enable;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_accept = -100;
    bit   prev_valid = 0;
    bit   rand_rdy = 0;
    vec_t exp_q [$];

    slow_split_if bus ();

    slow_split dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = 16'(a);
        v[1] = 16'(b);
        v[2] = 16'(c);
        v[3] = 16'(d);
        return v;
    endfunction

    function automatic logic [15:0] ref_lane(input logic signed [15:0] d,
                                             input logic signed [15:0] g);
        longint p;
        longint r;
        p = longint'(d) * longint'(g);
        r = (p + 64'sd8192) >>> 14;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    // Monitor: latency, exclusivity and scoreboard compare
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.dout_valid && !prev_valid)
                chk("latency", longint'(cyc - last_accept), 9);
            if (bus.dout_valid)
                chk("ready_valid_excl", longint'(bus.din_ready), 0);
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: output with empty queue");
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    for (int i = 0; i < 4; i++)
                        chk($sformatf("lane%0d", i),
                            longint'(bus.dout[i]), longint'($signed(e[i])));
                end
            end
        end
        prev_valid = bus.dout_valid;
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.dout_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic signed [15:0] d,
                        input logic signed [15:0] g0, input logic signed [15:0] g1,
                        input logic signed [15:0] g2, input logic signed [15:0] g3,
                        input vec_t e, input bit chk_space);
        int n;
        n = 0;
        @(negedge clk);
        bus.din = d;
        bus.gain[0] = g0;
        bus.gain[1] = g1;
        bus.gain[2] = g2;
        bus.gain[3] = g3;
        bus.din_valid = 1'b1;
        exp_q.push_back(e);
        while (!bus.din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: din_ready never rose");
            void'(exp_q.pop_back());
        end else begin
            if (chk_space)
                chk("accept_spacing", longint'(cyc + 1 - last_accept), 11);
            last_accept = cyc + 1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        vec_t e;
        logic signed [15:0] d;
        logic signed [15:0] g [4];
        int n;

        reset = 1'b1;
        enable = 1'b1;
        bus.din = '0;
        bus.gain = '{default: '0};
        bus.din_valid = 1'b0;
        bus.dout_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_din_ready", longint'(bus.din_ready), 0);
        chk("rst_dout_valid", longint'(bus.dout_valid), 0);
        chk("rst_dout0", longint'(bus.dout[0]), 0);
        chk("rst_dout3", longint'(bus.dout[3]), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("init_din_ready", longint'(bus.din_ready), 1);

        // Directed vectors
        send(1000, 16384, 8192, -16384, 0, mk(1000, 500, -1000, 0), 0);
        send(30000, 32767, -32768, 16384, 0, mk(32767, -32768, 30000, 0), 0);
        send(-32768, 32767, 0, 0, 0, mk(-32768, 0, 0, 0), 0);
        send(3, 8192, 8191, -8192, 16384, mk(2, 1, -1, 3), 0);
        send(-3, 8192, 0, 0, 0, mk(-1, 0, 0, 0), 0);
        send(1, 8191, 0, 0, 0, mk(0, 0, 0, 0), 0);
        drain();

        // Backpressure with input churn during hold
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b0;
        send(2000, 16384, 16384, 8192, -8192, mk(2000, 2000, 1000, -1000), 0);
        n = 0;
        while (!bus.dout_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", longint'(bus.dout_valid), 1);
        for (int i = 0; i < 5; i++) begin
            bus.din = 16'($urandom);
            bus.gain[0] = 16'($urandom);
            bus.gain[2] = 16'($urandom);
            bus.din_valid = 1'b1;
            @(negedge clk);
            chk("bp_hold_lane0", longint'(bus.dout[0]), 2000);
            chk("bp_hold_lane3", longint'(bus.dout[3]), -1000);
            chk("bp_din_ready", longint'(bus.din_ready), 0);
        end
        bus.din_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_din_ready", longint'(bus.din_ready), 1);
        chk("bp_release_valid", longint'(bus.dout_valid), 0);

        // Async reset during lane-2 multiply
        send(1000, 16384, 8192, -16384, 0, mk(1000, 500, -1000, 0), 0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_rst_valid", longint'(bus.dout_valid), 0);
        chk("abort_rst_dout0", longint'(bus.dout[0]), 0);
        chk("abort_rst_dout2", longint'(bus.dout[2]), 0);
        chk("abort_rst_din_ready", longint'(bus.din_ready), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rst_ready_back", longint'(bus.din_ready), 1);
        send(100, 16384, 16384, 16384, 16384, mk(100, 100, 100, 100), 0);
        drain();

        // Synchronous clear during lane-2 multiply
        send(1000, 16384, 8192, -16384, 0, mk(1000, 500, -1000, 0), 0);
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        chk("abort_en_pre_edge", longint'(bus.dout[0]), 100);
        @(posedge clk);
        #1;
        chk("abort_en_valid", longint'(bus.dout_valid), 0);
        chk("abort_en_dout0", longint'(bus.dout[0]), 0);
        chk("abort_en_din_ready", longint'(bus.din_ready), 0);
        exp_q.delete();
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_en_ready_back", longint'(bus.din_ready), 1);
        send(100, 16384, 16384, 16384, 16384, mk(100, 100, 100, 100), 0);
        drain();

        // Random stream with random downstream ready
        rand_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d = 16'($urandom);
            for (int i = 0; i < 4; i++) g[i] = 16'($urandom);
            for (int i = 0; i < 4; i++) e[i] = ref_lane(d, g[i]);
            send(d, g[0], g[1], g[2], g[3], e, 0);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b1;
        drain();

        // Back-to-back with ready held high
        for (int k = 0; k < 6; k++) begin
            d = 16'($urandom);
            for (int i = 0; i < 4; i++) g[i] = 16'($urandom);
            for (int i = 0; i < 4; i++) e[i] = ref_lane(d, g[i]);
            send(d, g[0], g[1], g[2], g[3], e, k != 0);
        end
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
